// File: rtl/alu_cmd_sequencer.sv
// Command sequencer that steps one command at a time through an external
// registered ALU and returns the result on a valid/ready response channel.
module alu_cmd_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   input  logic [2:0]       cmd_op,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [2:0]       alu_op,
   input  logic [3:0]       alu_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [3:0]       rsp_data,
   output logic             rsp_err,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t             state_reg, state_next;
   logic [3:0]         a_reg, a_next;
   logic [3:0]         b_reg, b_next;
   logic [2:0]         op_reg, op_next;
   logic [3:0]         rsp_data_reg, rsp_data_next;
   logic               rsp_err_reg, rsp_err_next;
   logic [CNT_W-1:0]   done_cnt_reg, done_cnt_next;
   logic               op_legal;

   // Opcodes 000..100 are defined; everything above is rejected without using the ALU.
   assign op_legal = (cmd_op <= 3'd4);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         a_reg        <= '0;
         b_reg        <= '0;
         op_reg       <= '0;
         rsp_data_reg <= '0;
         rsp_err_reg  <= 1'b0;
         done_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         a_reg        <= a_next;
         b_reg        <= b_next;
         op_reg       <= op_next;
         rsp_data_reg <= rsp_data_next;
         rsp_err_reg  <= rsp_err_next;
         done_cnt_reg <= done_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      a_next        = a_reg;
      b_next        = b_reg;
      op_next       = op_reg;
      rsp_data_next = rsp_data_reg;
      rsp_err_next  = rsp_err_reg;
      done_cnt_next = done_cnt_reg;

      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               a_next  = cmd_a;
               b_next  = cmd_b;
               op_next = cmd_op;
               if (op_legal) begin
                  state_next = ISSUE;
               end else begin
                  rsp_data_next = 4'd0;
                  rsp_err_next  = 1'b1;
                  state_next    = RESP;
               end
            end
         end
         ISSUE: begin
            // The ALU registers its result on this cycle's ending edge.
            state_next = CAPTURE;
         end
         CAPTURE: begin
            rsp_data_next = alu_out;
            rsp_err_next  = 1'b0;
            state_next    = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               done_cnt_next = done_cnt_reg + CNT_W'(1);
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign cmd_ready = (state_reg == IDLE);
   assign rsp_valid = (state_reg == RESP);
   assign alu_a     = a_reg;
   assign alu_b     = b_reg;
   assign alu_op    = op_reg;
   assign rsp_data  = rsp_data_reg;
   assign rsp_err   = rsp_err_reg;
   assign done_cnt  = done_cnt_reg;

endmodule
